// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit width, FSM state encoding, error nibble and the add-3 correction.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] BCD_ERR_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Double-dabble correction: a digit of 5 or more becomes >= 10 after the
  // next doubling, so it is pre-biased by 3 to carry into the next digit.
  function automatic logic [BCD_DIGIT_W-1:0] add3_digit(
    input logic [BCD_DIGIT_W-1:0] d
  );
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Conversion request/result bundle between a producer (master) and the
// binary-to-BCD converter (slave).
interface bin_to_bcd_seq_if #(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
);

  // Handshake: the producer raises start with bin while busy is low; the
  // request is taken on that rising edge (also in the done cycle). While
  // busy is high start is ignored, not queued. done pulses for one cycle
  // when bcd/ovf carry the new result, and they hold until the next one.
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   bcd;
  logic                ovf;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output ovf
  );

endinterface

// File: rtl/bcd_add3.sv
// Single BCD digit correction cell used by the double-dabble datapath.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] in_i,
  output logic [BCD_DIGIT_W-1:0] out_o
);

  assign out_o = add3_digit(in_i);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with a start/busy/done handshake and an overflow-to-error-pattern result.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_bcd_seq_if.slave bus,
  output state_e          state_o
);

  localparam int SCR_W = BCD_DIGIT_W * NDIG;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0]      MAX_VAL  = 64'(10 ** NDIG) - 64'd1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [SCR_W-1:0] ERR_WORD = {NDIG{BCD_ERR_NIBBLE}};

  state_e             state_q;
  logic [BIN_W-1:0]   shift_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pend_q;
  logic               busy_q;
  logic               done_q;
  logic [SCR_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [SCR_W-1:0]   corr;
  logic [SCR_W-1:0]   scratch_d;
  logic [BIN_W-1:0]   shift_d;
  logic               last_iter;
  logic               over_max;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .out_o (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Carry out of the top digit is dropped; overflow comes from pend_q.
  always_comb begin
    scratch_d = {corr[SCR_W-2:0], shift_q[BIN_W-1]};
    shift_d   = {shift_q[BIN_W-2:0], 1'b0};
    last_iter = (cnt_q == CNT_W'(1));
    over_max  = (64'(bus.bin) > MAX_VAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (last_iter) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ovf_q   <= pend_q;
            bcd_q   <= pend_q ? ERR_WORD : scratch_d;
          end
        end
        // IDLE and DONE both accept a new request; DONE lasts one cycle.
        default: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
            shift_q   <= bus.bin;
            scratch_q <= '0;
            cnt_q     <= CNT_LOAD;
            pend_q    <= over_max;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: reset, conversions, ignored start,
// overflow error pattern, mid-conversion reset and back-to-back starts.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_e state_o;

  bin_to_bcd_seq_if bus ();

  bin_to_bcd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] cur_bcd;
  logic        cur_ovf;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with start low; returns at the negedge of the DONE
  // cycle (cycle 15), so a follow-up call there is a back-to-back start.
  task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input bit inject);
    bus.start = 1'b1;
    bus.bin   = v;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (inject && c == 5) begin
        bus.start = 1'b1;
        bus.bin   = 14'd5;
      end
      if (inject && c == 6) bus.start = 1'b0;
      check("busy_in_shift", 32'(bus.busy), 32'd1);
      check("done_in_shift", 32'(bus.done), 32'd0);
      if (c == 7) begin
        check("bcd_held", 32'(bus.bcd), 32'(cur_bcd));
        check("ovf_held", 32'(bus.ovf), 32'(cur_ovf));
      end
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("bcd_result", 32'(bus.bcd), 32'(exp_bcd));
    check("ovf_result", 32'(bus.ovf), 32'(exp_ovf));
    check("state_done", 32'(state_o), 32'(DONE));
    cur_bcd = exp_bcd;
    cur_ovf = exp_ovf;
  endtask

  task automatic idle_step();
    @(negedge clk);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_bcd", 32'(bus.bcd), 32'(cur_bcd));
    check("idle_state", 32'(state_o), 32'(IDLE));
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.bin   = 14'd123;
    cur_bcd   = 16'h0000;
    cur_ovf   = 1'b0;

    // reset dominates a held start
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_bcd", 32'(bus.bcd), 32'h0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_state", 32'(state_o), 32'(IDLE));
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    idle_step();

    run_conv(14'd0, 16'h0000, 1'b0, 1'b0);
    idle_step();
    run_conv(14'd9999, 16'h9999, 1'b0, 1'b0);
    idle_step();
    run_conv(14'd1234, 16'h1234, 1'b0, 1'b0);
    idle_step();

    // start while busy is ignored; no second done afterwards
    run_conv(14'd1234, 16'h1234, 1'b0, 1'b1);
    idle_step();
    idle_step();

    run_conv(14'd10000, 16'hFFFF, 1'b1, 1'b0);
    idle_step();
    run_conv(14'd16383, 16'hFFFF, 1'b1, 1'b0);
    idle_step();
    run_conv(14'd7, 16'h0007, 1'b0, 1'b0);
    idle_step();
    run_conv(14'd42, 16'h0042, 1'b0, 1'b0);
    idle_step();

    // reset at cycle 7 aborts the conversion
    bus.start = 1'b1;
    bus.bin   = 14'd4321;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd1);
      check("abort_bcd_held", 32'(bus.bcd), 32'h0042);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_low", 32'(bus.busy), 32'd0);
    check("abort_no_done", 32'(bus.done), 32'd0);
    check("abort_bcd_zero", 32'(bus.bcd), 32'h0);
    check("abort_ovf_zero", 32'(bus.ovf), 32'd0);
    cur_bcd = 16'h0000;
    cur_ovf = 1'b0;
    repeat (3) idle_step();

    // back-to-back: second start in the first conversion's DONE cycle
    run_conv(14'd4321, 16'h4321, 1'b0, 1'b0);
    run_conv(14'd56, 16'h0056, 1'b0, 1'b0);
    idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
